regfile_sb: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and an integrated per-register pending scoreboard, replacing the fixed 32x32, two-read-port behavioural register memory in the pipelined datapath. Reads are combinational for the decode stage. The single write port is clocked and fed from writeback. Decode uses the scoreboard (claim at issue, clear at writeback) to raise a stall request when a source operand is still owed by an in-flight instruction.

---
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending scoreboard (claimed at issue, cleared at writeback).
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_use,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [DEPTH-1:0]           busy_vec
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_ok;
    logic              claim_ok;

    // An address is usable when it is in range and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok    = wr_en && addr_ok(wr_addr);
    assign claim_ok = claim_en && addr_ok(claim_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The claim is assigned last so a same-edge new producer outranks the retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[wr_addr] <= 1'b0;
            end
            if (claim_ok) begin
                pending[claim_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic              byp;

        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit = addr_ok(a);
        assign byp = (BYPASS != 0) && wr_ok && (wr_addr == a);

        assign rd_data[i*DATA_W +: DATA_W] = byp ? wr_data : (hit ? mem[a] : '0);
        assign rd_busy[i] = hit && pending[a] && !byp;
    end

    assign stall    = |(rd_busy & rd_use);
    assign busy_vec = pending;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb with default parameters,
// plus a hand-written asynchronous reset sequence.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_use;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [31:0] busy_vec;

    int n_vec  = 0;
    int n_fail = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_use     (rd_use),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .stall      (stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        claim_en;
        logic [4:0]  claim_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  use_mask;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        stall;
        logic [31:0] bv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic ce, logic [4:0] ca, logic [4:0] a0, logic [4:0] a1,
                                logic [1:0] u, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] b, logic s, logic [31:0] bv);
        vec_t v;
        v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.claim_en = ce; v.claim_addr = ca; v.ra0 = a0; v.ra1 = a1;
        v.use_mask = u; v.d0 = d0; v.d1 = d1; v.busy = b; v.stall = s; v.bv = bv;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t v, input int idx);
        n_vec++;
        chk("rd_data0", idx, rd_data[31:0], v.d0);
        chk("rd_data1", idx, rd_data[63:32], v.d1);
        chk("rd_busy", idx, {30'b0, rd_busy}, {30'b0, v.busy});
        chk("stall", idx, {31'b0, stall}, {31'b0, v.stall});
        chk("busy_vec", idx, busy_vec, v.bv);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // and the following rising edge commits the cycle.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst        = v.rst;
        wr_en      = v.wr_en;
        wr_addr    = v.wr_addr;
        wr_data    = v.wr_data;
        claim_en   = v.claim_en;
        claim_addr = v.claim_addr;
        rd_addr    = {v.ra1, v.ra0};
        rd_use     = v.use_mask;
        #1;
        check_outputs(v, idx);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; rd_addr = '0; rd_use = '0;

        //               rst we wa  wd            ce ca  a0  a1  use d0            d1     busy st bv
        tbl.push_back(mk(1, 1, 1,  32'h77,        0, 0,  1,  2,  0, 32'h77,       0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  1,  2,  0, 0,            0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  32'd10,        0, 0,  2,  1,  0, 0,            32'd10,0, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0,             0, 0,  2,  1,  0, 0,            32'd10,0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  2,  1,  0, 0,            32'd10,0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  32'hDEADBEEF,  1, 0,  0,  0,  3, 0,            0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  0,  1,  3, 0,            32'd10,0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             1, 5,  5,  1,  0, 0,            32'd10,0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  5,  1,  1, 0,            32'd10,1, 1, 32'h20));
        tbl.push_back(mk(0, 1, 5,  32'h1234,      0, 0,  5,  1,  1, 32'h1234,     32'd10,0, 0, 32'h20));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  5,  5,  3, 32'h1234,     32'h1234,0,0, 0));
        tbl.push_back(mk(0, 1, 7,  32'h55,        1, 7,  7,  5,  0, 32'h55,       32'h1234,0,0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  7,  7,  3, 32'h55,       32'h55,3, 1, 32'h80));
        tbl.push_back(mk(0, 1, 7,  32'h66,        0, 0,  7,  3,  0, 32'h66,       0,     0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0,  0,             1, 3,  7,  3,  0, 32'h66,       0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  7,  3,  1, 32'h66,       0,     2, 0, 32'h8));
        tbl.push_back(mk(0, 0, 0,  0,             1, 3,  7,  3,  2, 32'h66,       0,     2, 1, 32'h8));
        tbl.push_back(mk(0, 1, 3,  32'hA,         0, 0,  3,  3,  3, 32'hA,        32'hA, 0, 0, 32'h8));
        tbl.push_back(mk(0, 0, 0,  0,             0, 0,  3,  9,  3, 32'hA,        0,     0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Claims outstanding on r4 and r9, then an asynchronous reset between edges.
        apply(mk(0, 1, 4, 32'h44, 1, 4, 4, 1, 0, 32'h44, 32'd10, 0, 0, 0), 100);
        apply(mk(0, 0, 0, 0,      1, 9, 4, 9, 3, 32'h44, 0,      1, 1, 32'h10), 101);
        apply(mk(0, 0, 0, 0,      0, 0, 4, 1, 0, 32'h44, 32'd10, 1, 0, 32'h210), 102);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs(mk(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0), 103);
        rst_busy_probe: begin
            rd_addr = {5'd9, 5'd4};
            rd_use  = 2'b11;
            #0.5;
            check_outputs(mk(1, 0, 0, 0, 0, 0, 4, 9, 3, 0, 0, 0, 0, 0), 104);
        end
        #0.5;
        rst = 1'b0;
        apply(mk(0, 1, 4, 32'h99, 0, 0, 4, 9, 3, 32'h99, 0, 0, 0, 0), 105);
        apply(mk(0, 0, 0, 0,      1, 4, 4, 9, 3, 32'h99, 0, 0, 0, 0), 106);
        apply(mk(0, 0, 0, 0,      0, 0, 4, 1, 1, 32'h99, 0, 1, 1, 32'h10), 107);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
